// File: rtl/mcu_32x.sv
// mcu_32x: single-cycle 32-bit core with internal ROM, data RAM and 32x32 register file.
// Ports: clk, reset (sync, active-high), result/address (registered retire info), mem_read/mem_write (registered strobes).
module mcu_32x #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64,
  // Program image, word i at bits [32*i +: 32]; up to 64 words reachable by PC[7:2].
  parameter logic [2047:0] ROM_IMAGE = {
    {57{32'h0000_0000}},
    32'hFC00_0000,
    32'h08A4_0800,
    32'h2480_0010,
    32'h2860_0010,
    32'h0461_1000,
    32'h2040_0007,
    32'h2020_0005
  }
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] result,
  output logic [31:0] address,
  output logic        mem_read,
  output logic        mem_write
);

  localparam int DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_XOR  = 6'h05;
  localparam logic [5:0] OP_SLL  = 6'h06;
  localparam logic [5:0] OP_SRL  = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h09;
  localparam logic [5:0] OP_SW   = 6'h0A;
  localparam logic [5:0] OP_BEQ  = 6'h0B;
  localparam logic [5:0] OP_HALT = 6'h3F;

  // The PC only needs 8 bits: the ROM index is PC[7:2], so it wraps at 0x100.
  logic [7:0]  pc;
  logic        halted;
  logic [31:0] regs [32];
  logic [31:0] dmem [DMEM_WORDS];

  logic [5:0]     rom_idx;
  logic [31:0]    instr;
  logic [5:0]     op;
  logic [4:0]     rd;
  logic [4:0]     rs1;
  logic [4:0]     rs2;
  logic [31:0]    imm;
  logic [31:0]    rd_val;
  logic [31:0]    rs1_val;
  logic [31:0]    rs2_val;
  logic [31:0]    ea;
  logic [DAW-1:0] dmem_idx;
  logic [7:0]     pc_inc;
  logic [7:0]     br_tgt;

  logic        wb_en;
  logic [31:0] wb_val;
  logic        st_en;
  logic        halt_hit;
  logic [7:0]  nxt_pc;
  logic [31:0] nxt_res;
  logic [31:0] nxt_addr;
  logic        nxt_rd;
  logic        nxt_wr;

  assign rom_idx  = 6'({26'd0, pc[7:2]} % 32'(IMEM_WORDS));
  assign instr    = ROM_IMAGE[{rom_idx, 5'd0} +: 32];
  assign op       = instr[31:26];
  assign rd       = instr[25:21];
  assign rs1      = instr[20:16];
  assign rs2      = instr[15:11];
  assign imm      = {{16{instr[15]}}, instr[15:0]};
  assign rd_val   = regs[rd];
  assign rs1_val  = regs[rs1];
  assign rs2_val  = regs[rs2];
  assign ea       = rs1_val + imm;
  assign dmem_idx = DAW'({26'd0, ea[7:2]} % 32'(DMEM_WORDS));
  assign pc_inc   = pc + 8'd4;
  assign br_tgt   = pc_inc + {imm[5:0], 2'b00};

  always_comb begin
    wb_en    = 1'b0;
    wb_val   = 32'd0;
    st_en    = 1'b0;
    halt_hit = 1'b0;
    nxt_pc   = pc_inc;
    nxt_res  = 32'd0;
    nxt_addr = {24'd0, pc};
    nxt_rd   = 1'b0;
    nxt_wr   = 1'b0;
    case (op)
      OP_ADD:  begin wb_en = 1'b1; wb_val = rs1_val + rs2_val; end
      OP_SUB:  begin wb_en = 1'b1; wb_val = rs1_val - rs2_val; end
      OP_AND:  begin wb_en = 1'b1; wb_val = rs1_val & rs2_val; end
      OP_OR:   begin wb_en = 1'b1; wb_val = rs1_val | rs2_val; end
      OP_XOR:  begin wb_en = 1'b1; wb_val = rs1_val ^ rs2_val; end
      OP_SLL:  begin wb_en = 1'b1; wb_val = rs1_val << rs2_val[4:0]; end
      OP_SRL:  begin wb_en = 1'b1; wb_val = rs1_val >> rs2_val[4:0]; end
      OP_ADDI: begin wb_en = 1'b1; wb_val = ea; end
      OP_LW: begin
        wb_en    = 1'b1;
        wb_val   = dmem[dmem_idx];
        nxt_addr = ea;
        nxt_rd   = 1'b1;
      end
      OP_SW: begin
        st_en    = 1'b1;
        nxt_res  = rd_val;
        nxt_addr = ea;
        nxt_wr   = 1'b1;
      end
      OP_BEQ: begin
        nxt_pc  = (rd_val == rs1_val) ? br_tgt : pc_inc;
        nxt_res = {24'd0, nxt_pc};
      end
      OP_HALT: begin
        halt_hit = 1'b1;
        nxt_pc   = pc;
      end
      default: ;
    endcase
    if (wb_en) nxt_res = wb_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= 8'd0;
      halted    <= 1'b0;
      result    <= 32'd0;
      address   <= 32'd0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= 32'd0;
    end else if (halted) begin
      result    <= 32'd0;
      address   <= {24'd0, pc};
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      pc        <= nxt_pc;
      halted    <= halt_hit;
      result    <= nxt_res;
      address   <= nxt_addr;
      mem_read  <= nxt_rd;
      mem_write <= nxt_wr;
      // r0 stays zero because it is never written.
      if (wb_en && rd != 5'd0) regs[rd] <= wb_val;
      if (st_en) dmem[dmem_idx] <= rd_val;
    end
  end

endmodule

// File: tb/tb_mcu_32x.sv
// tb_mcu_32x: two mcu_32x instances (default ROM and an alternate program)
// compared each cycle against an instruction-level model, plus directed checks.
module tb_mcu_32x;

  function automatic logic [31:0] enc(input int op, input int rd,
                                      input int rs1, input int imm);
    logic [31:0] w;
    w = {op[5:0], rd[4:0], rs1[4:0], imm[15:0]};
    return w;
  endfunction

  function automatic logic [31:0] rr(input int op, input int rd,
                                     input int rs1, input int rs2);
    return enc(op, rd, rs1, rs2 * 2048);
  endfunction

  function automatic logic [2047:0] def_img();
    logic [2047:0] v;
    v = '0;
    v[0*32 +: 32] = enc(8, 1, 0, 5);
    v[1*32 +: 32] = enc(8, 2, 0, 7);
    v[2*32 +: 32] = rr(1, 3, 1, 2);
    v[3*32 +: 32] = enc(10, 3, 0, 16);
    v[4*32 +: 32] = enc(9, 4, 0, 16);
    v[5*32 +: 32] = rr(2, 5, 4, 1);
    v[6*32 +: 32] = enc(63, 0, 0, 0);
    return v;
  endfunction

  function automatic logic [2047:0] alt_img();
    logic [2047:0] v;
    v = '0;
    v[0*32 +: 32]  = enc(8, 0, 0, 9);
    v[1*32 +: 32]  = rr(1, 1, 0, 0);
    v[2*32 +: 32]  = enc(8, 2, 0, 1);
    v[3*32 +: 32]  = enc(8, 6, 0, 31);
    v[4*32 +: 32]  = rr(6, 3, 2, 6);
    v[5*32 +: 32]  = rr(7, 4, 3, 6);
    v[6*32 +: 32]  = enc(11, 4, 2, 1);
    v[7*32 +: 32]  = enc(8, 7, 0, 'h7FF);
    v[8*32 +: 32]  = enc(11, 4, 0, 5);
    v[9*32 +: 32]  = enc('h20, 1, 2, 3);
    v[10*32 +: 32] = rr(5, 8, 3, 2);
    v[11*32 +: 32] = rr(2, 11, 0, 2);
    v[12*32 +: 32] = rr(3, 12, 11, 3);
    v[13*32 +: 32] = rr(4, 13, 12, 2);
    v[14*32 +: 32] = enc(11, 0, 0, 45);
    v[60*32 +: 32] = enc(8, 9, 9, 1);
    v[61*32 +: 32] = enc(10, 9, 3, 4);
    v[62*32 +: 32] = enc(9, 10, 0, 4);
    v[63*32 +: 32] = enc(8, 14, 14, 'hFFFF);
    return v;
  endfunction

  localparam logic [2047:0] ALT = alt_img();

  logic        clk;
  logic        rst_a, rst_b;
  logic [31:0] res_a, addr_a, res_b, addr_b;
  logic        rd_a, wr_a, rd_b, wr_b;

  mcu_32x dut_a (
    .clk(clk), .reset(rst_a), .result(res_a), .address(addr_a),
    .mem_read(rd_a), .mem_write(wr_a)
  );

  mcu_32x #(.ROM_IMAGE(ALT)) dut_b (
    .clk(clk), .reset(rst_b), .result(res_b), .address(addr_b),
    .mem_read(rd_b), .mem_write(wr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instruction-level model state, one slot per DUT.
  logic [31:0] rom   [2][64];
  logic [31:0] m_reg [2][32];
  logic [31:0] m_mem [2][64];
  logic [31:0] m_pc  [2];
  logic        m_halt[2];
  logic [31:0] e_res [2];
  logic [31:0] e_addr[2];
  logic        e_rd  [2];
  logic        e_wr  [2];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mstep(input int d, input logic rst);
    logic [31:0] ins, a, b, c, imm, ea, wv, npc;
    int op, rd, rs1, rs2;
    logic wb;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_reg[d][i] = 0;
      for (int i = 0; i < 64; i++) m_mem[d][i] = 0;
      m_pc[d] = 0; m_halt[d] = 0;
      e_res[d] = 0; e_addr[d] = 0; e_rd[d] = 0; e_wr[d] = 0;
      return;
    end
    e_res[d] = 0; e_addr[d] = m_pc[d]; e_rd[d] = 0; e_wr[d] = 0;
    if (m_halt[d]) return;
    ins = rom[d][(m_pc[d] / 4) % 64];
    op = int'(ins[31:26]); rd = int'(ins[25:21]);
    rs1 = int'(ins[20:16]); rs2 = int'(ins[15:11]);
    c = m_reg[d][rd]; a = m_reg[d][rs1]; b = m_reg[d][rs2];
    imm = {{16{ins[15]}}, ins[15:0]};
    npc = (m_pc[d] + 4) % 256;
    wb = 0; wv = 0;
    case (op)
      1: begin wb = 1; wv = a + b; end
      2: begin wb = 1; wv = a - b; end
      3: begin wb = 1; wv = a & b; end
      4: begin wb = 1; wv = a | b; end
      5: begin wb = 1; wv = a ^ b; end
      6: begin wb = 1; wv = a << (b % 32); end
      7: begin wb = 1; wv = a >> (b % 32); end
      8: begin wb = 1; wv = a + imm; end
      9: begin
        ea = a + imm;
        wb = 1; wv = m_mem[d][(ea / 4) % 64];
        e_addr[d] = ea; e_rd[d] = 1;
      end
      10: begin
        ea = a + imm;
        m_mem[d][(ea / 4) % 64] = c;
        e_res[d] = c; e_addr[d] = ea; e_wr[d] = 1;
      end
      11: begin
        if (c == a) npc = (m_pc[d] + 4 + imm * 4) % 256;
        e_res[d] = npc;
      end
      63: begin m_halt[d] = 1; npc = m_pc[d]; end
      default: ;
    endcase
    if (wb) begin
      e_res[d] = wv;
      if (rd != 0) m_reg[d][rd] = wv;
    end
    m_pc[d] = npc;
  endtask

  task automatic chk_model(input int d);
    if (d == 0) begin
      check("m0_result", res_a, e_res[0]);
      check("m0_address", addr_a, e_addr[0]);
      check("m0_mem_read", {31'd0, rd_a}, {31'd0, e_rd[0]});
      check("m0_mem_write", {31'd0, wr_a}, {31'd0, e_wr[0]});
    end else begin
      check("m1_result", res_b, e_res[1]);
      check("m1_address", addr_b, e_addr[1]);
      check("m1_mem_read", {31'd0, rd_b}, {31'd0, e_rd[1]});
      check("m1_mem_write", {31'd0, wr_b}, {31'd0, e_wr[1]});
    end
  endtask

  task automatic tick(input logic ra, input logic rb);
    rst_a = ra; rst_b = rb;
    @(posedge clk);
    mstep(0, ra);
    mstep(1, rb);
    #1;
    chk_model(0);
    chk_model(1);
  endtask

  task automatic chk_a(input string tag, input logic [31:0] r,
                       input logic [31:0] ad, input logic mr,
                       input logic mw);
    check({tag, "_result"}, res_a, r);
    check({tag, "_address"}, addr_a, ad);
    check({tag, "_mem_read"}, {31'd0, rd_a}, {31'd0, mr});
    check({tag, "_mem_write"}, {31'd0, wr_a}, {31'd0, mw});
  endtask

  logic [31:0] exp_res [7];
  logic [31:0] exp_addr[7];
  logic        exp_rd  [7];
  logic        exp_wr  [7];

  initial begin
    logic [2047:0] di;
    di = def_img();
    for (int i = 0; i < 64; i++) begin
      rom[0][i] = di[i*32 +: 32];
      rom[1][i] = ALT[i*32 +: 32];
    end
    exp_res  = '{5, 7, 12, 12, 12, 7, 0};
    exp_addr = '{'h0, 'h4, 'h8, 'h10, 'h10, 'h14, 'h18};
    exp_rd   = '{0, 0, 0, 0, 1, 0, 0};
    exp_wr   = '{0, 0, 0, 1, 0, 0, 0};
    rst_a = 1'b1; rst_b = 1'b1;

    tick(1, 1);
    tick(1, 1);
    chk_a("reset", 0, 0, 0, 0);

    for (int e = 0; e < 7; e++) begin
      tick(0, 1);
      chk_a($sformatf("edge%0d", e + 1), exp_res[e], exp_addr[e],
            exp_rd[e], exp_wr[e]);
    end
    for (int k = 0; k < 20; k++) begin
      tick(0, 1);
      chk_a($sformatf("halt%0d", k), 0, 'h18, 0, 0);
    end

    tick(1, 1);
    for (int e = 0; e < 4; e++) tick(0, 1);
    tick(1, 1);
    chk_a("midreset", 0, 0, 0, 0);
    tick(0, 1);
    chk_a("restart", 5, 0, 0, 0);

    tick(1, 1);
    for (int e = 1; e <= 19; e++) begin
      tick(0, 0);
      case (e)
        2: check("alt_r0_add", res_b, 0);
        6: check("alt_srl31", res_b, 1);
        7: begin
          check("alt_beq_taken", res_b, 'h20);
          check("alt_beq_pc", addr_b, 'h18);
        end
        8: begin
          check("alt_beq_not", res_b, 'h24);
          check("alt_skip_pc", addr_b, 'h20);
        end
        16: begin
          check("alt_sw_addr", addr_b, 'h8000_0004);
          check("alt_sw_wr", {31'd0, wr_b}, 1);
        end
        17: begin
          check("alt_lw_fwd", res_b, 1);
          check("alt_lw_rd", {31'd0, rd_b}, 1);
        end
        18: begin
          check("alt_pc_fc", addr_b, 'hFC);
          check("alt_wrap_sub", res_b, 'hFFFF_FFFF);
        end
        19: check("alt_pc_wrap", addr_b, 0);
        default: ;
      endcase
    end

    for (int k = 0; k < 600; k++) begin
      tick($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcu_32x.md
MCU_32X -- requirements
Module: mcu_32x

Interface
REQ-001 Parameters (name, default, meaning): IMEM_WORDS, 64, instruction ROM depth in words; DMEM_WORDS, 64, data RAM depth in words.
REQ-002 clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 result  output  32  registered value produced by the instruction retired at the last edge.
REQ-005 address  output  32  registered effective byte address (LW/SW) or PC of the retired instruction (all others).
REQ-006 mem_read  output  1  registered; high for exactly the cycle after an LW retires.
REQ-007 mem_write  output  1  registered; high for exactly the cycle after an SW retires.

Function
REQ-008 Single-cycle core: one instruction fetched from internal ROM and retired per rising edge while not halted; no stalls.
REQ-009 Instruction fields: op=[31:26], rd=[25:21], rs1=[20:16], rs2=[15:11], imm=[15:0] sign-extended to 32 bits.
REQ-010 Register file: 32 x 32-bit; r0 reads 0 and ignores writes; reads are combinational, writes occur at the retiring edge.
REQ-011 Opcodes: 0x00 NOP; 0x01 ADD; 0x02 SUB; 0x03 AND; 0x04 OR; 0x05 XOR; 0x06 SLL by rs2[4:0]; 0x07 SRL (logical) by rs2[4:0]; 0x08 ADDI rd=rs1+imm; 0x09 LW rd=mem[rs1+imm]; 0x0A SW mem[rs1+imm]=rd; 0x0B BEQ if rd==rs1 then PC=PC+4+(imm<<2); 0x3F HALT.
REQ-012 Any other opcode executes as NOP.
REQ-013 Arithmetic is 32-bit modulo 2^32; overflow and carry are discarded.
REQ-014 PC is a byte address that advances by 4; ROM index is PC[7:2] modulo IMEM_WORDS, so the PC wraps past the end.
REQ-015 Data RAM is word-addressed by effective address [7:2] modulo DMEM_WORDS; bits [1:0] are ignored; there are no misalignment faults.
REQ-016 LW issued directly after an SW to the same word returns the newly stored data.
REQ-017 result per class: ALU/ADDI gives rd value written; LW gives loaded data; SW gives stored data; BEQ gives next PC; NOP/HALT give 0.
REQ-018 HALT freezes PC and all architectural state; every later cycle outputs result=0, address=PC of HALT, mem_read=0, mem_write=0 until reset.
REQ-019 The ROM contents at power-up are fixed, with words beyond 6 equal to 0: w0 ADDI r1,r0,5; w1 ADDI r2,r0,7; w2 ADD r3,r1,r2; w3 SW r3,16(r0); w4 LW r4,16(r0); w5 SUB r5,r4,r1; w6 HALT.

Reset
REQ-020 While reset is high at an edge: PC=0, registers=0, data RAM=0, halt flag cleared, result=0, address=0, mem_read=0, mem_write=0.
REQ-021 Reset has priority over instruction execution at the same edge; asserting it mid-program (including after HALT) restarts execution from PC 0.
REQ-022 The first edge with reset low executes ROM word 0.

Verification
REQ-023 Release reset, then watch edges 1-3 after release -> result 5/7/12, address 0x0/0x4/0x8, mem flags 0.
REQ-024 Edge 4 -> result 12, address 0x10, mem_write=1, mem_read=0; edge 5 -> result 12, address 0x10, mem_read=1, mem_write=0.
REQ-025 Edge 6 -> result 7, address 0x14; edges 7+ -> result 0, address 0x18, flags 0, held for 20 cycles.
REQ-026 Assert reset for 1 cycle at edge 5 -> all outputs 0; after release the sequence repeats from result 5.
REQ-027 Alternate ROM preload exercising BEQ taken/not-taken, r0 write (ADDI r0,r0,9 then ADD r1,r0,r0 gives result 0), SRL of 0x80000000 by 31 giving 1, and PC wrap from 0xFC to 0x00.
